// File: rtl/gpio_pad_ctrl_pkg.sv
// Shared types and helpers for the GPIO pad front end.
// Holds the block-level INIT/RUN state encoding and the sizing rule for the init counter.
package gpio_pad_ctrl_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Width of a counter that can hold 0..sync_stages+1.
    function automatic int init_cnt_width(input int sync_stages);
        return $clog2(sync_stages + 2);
    endfunction

endpackage

// File: rtl/gpio_pad_ctrl_pin.sv
// One GPIO pin input path: synchroniser, debounce filter, edge detect and sticky interrupt bit.
// The filter and edge detector are preloaded from the synchroniser while the block is in INIT.
module gpio_pad_ctrl_pin
    import gpio_pad_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DBNC_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  run_i,
    input  logic                  pad_c_i,
    input  logic                  dbnc_en_i,
    input  logic [DBNC_WIDTH-1:0] dbnc_lmt_i,
    input  logic                  rise_en_i,
    input  logic                  fall_en_i,
    input  logic                  int_clr_i,
    output logic                  in_o,
    output logic                  int_stat_o,
    output logic                  int_nxt_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_filt;
    logic                   r_filt_q;
    logic [DBNC_WIDTH-1:0]  r_cnt;
    logic                   r_int_stat;

    logic                   w_sync;
    logic                   w_bypass;
    logic [DBNC_WIDTH-1:0]  w_lmt_m1;
    logic                   w_filt_nxt;
    logic                   w_filt_q_nxt;
    logic [DBNC_WIDTH-1:0]  w_cnt_nxt;
    logic                   w_rise;
    logic                   w_fall;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_bypass = ~dbnc_en_i | (dbnc_lmt_i == '0);
    assign w_lmt_m1 = dbnc_lmt_i - DBNC_WIDTH'(1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_filt_nxt   = r_filt;
        w_filt_q_nxt = r_filt;
        w_cnt_nxt    = r_cnt;
        if (!run_i) begin
            // Loading filt_q with the same value as filt means RUN starts with no edge pending.
            w_filt_nxt   = w_sync;
            w_filt_q_nxt = w_sync;
            w_cnt_nxt    = '0;
        end else if (w_bypass) begin
            w_filt_nxt = w_sync;
            w_cnt_nxt  = '0;
        end else if (w_sync == r_filt) begin
            w_cnt_nxt = '0;
        end else if (r_cnt >= w_lmt_m1) begin
            w_filt_nxt = w_sync;
            w_cnt_nxt  = '0;
        end else begin
            w_cnt_nxt = r_cnt + DBNC_WIDTH'(1);
        end
    end

    assign w_rise    = run_i &  r_filt & ~r_filt_q;
    assign w_fall    = run_i & ~r_filt &  r_filt_q;
    assign int_nxt_o = (r_int_stat & ~int_clr_i) | (w_rise & rise_en_i) | (w_fall & fall_en_i);

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync     <= '0;
            r_filt     <= 1'b0;
            r_filt_q   <= 1'b0;
            r_cnt      <= '0;
            r_int_stat <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], pad_c_i};
            r_filt     <= w_filt_nxt;
            r_filt_q   <= w_filt_q_nxt;
            r_cnt      <= w_cnt_nxt;
            r_int_stat <= int_nxt_o;
        end
    end

    assign in_o       = r_filt;
    assign int_stat_o = r_int_stat;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad front end: registered pad controls, per-pin filtered inputs and an aggregated IRQ.
// A shared controller holds all pins in INIT for SYNC_STAGES+1 cycles after reset, then RUN.
module gpio_pad_ctrl
    import gpio_pad_ctrl_pkg::*;
#(
    parameter int GPIO_NUM    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DBNC_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [GPIO_NUM-1:0]   out_i,
    input  logic [GPIO_NUM-1:0]   oe_i,
    input  logic [GPIO_NUM-1:0]   pu_en_i,
    input  logic [GPIO_NUM-1:0]   dbnc_en_i,
    input  logic [DBNC_WIDTH-1:0] dbnc_lmt_i,
    input  logic [GPIO_NUM-1:0]   rise_en_i,
    input  logic [GPIO_NUM-1:0]   fall_en_i,
    input  logic [GPIO_NUM-1:0]   int_clr_i,
    output logic [GPIO_NUM-1:0]   pad_i_o,
    output logic [GPIO_NUM-1:0]   pad_oen_o,
    output logic [GPIO_NUM-1:0]   pad_ren_o,
    input  logic [GPIO_NUM-1:0]   pad_c_i,
    output logic [GPIO_NUM-1:0]   in_o,
    output logic [GPIO_NUM-1:0]   int_stat_o,
    output logic                  irq_o
);

    localparam int               INIT_CNT_W = init_cnt_width(SYNC_STAGES);
    localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(SYNC_STAGES);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [INIT_CNT_W-1:0] r_init_cnt;
    logic [INIT_CNT_W-1:0] w_init_cnt_nxt;
    logic                  w_run;
    logic [GPIO_NUM-1:0]   w_int_nxt;
    logic [GPIO_NUM-1:0]   r_pad_i;
    logic [GPIO_NUM-1:0]   r_pad_oen;
    logic [GPIO_NUM-1:0]   r_pad_ren;
    logic                  r_irq;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        case (r_state)
            INIT: begin
                w_init_cnt_nxt = r_init_cnt + INIT_CNT_W'(1);
                if (r_init_cnt == INIT_LAST) begin
                    w_state_nxt    = RUN;
                    w_init_cnt_nxt = '0;
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = INIT;
        endcase
    end

    assign w_run = (r_state == RUN);

    // Pad controls are registered so the pad never sees glitches from the register block.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pad_i   <= '0;
            r_pad_oen <= '0;
            r_pad_ren <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_pad_i   <= out_i;
            r_pad_oen <= oe_i;
            r_pad_ren <= pu_en_i;
            r_irq     <= |w_int_nxt;
        end
    end

    for (genvar g = 0; g < GPIO_NUM; g++) begin : g_pin
        gpio_pad_ctrl_pin #(
            .SYNC_STAGES (SYNC_STAGES),
            .DBNC_WIDTH  (DBNC_WIDTH)
        ) u_pin (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .run_i      (w_run),
            .pad_c_i    (pad_c_i[g]),
            .dbnc_en_i  (dbnc_en_i[g]),
            .dbnc_lmt_i (dbnc_lmt_i),
            .rise_en_i  (rise_en_i[g]),
            .fall_en_i  (fall_en_i[g]),
            .int_clr_i  (int_clr_i[g]),
            .in_o       (in_o[g]),
            .int_stat_o (int_stat_o[g]),
            .int_nxt_o  (w_int_nxt[g])
        );
    end

    assign pad_i_o   = r_pad_i;
    assign pad_oen_o = r_pad_oen;
    assign pad_ren_o = r_pad_ren;
    assign irq_o     = r_irq;

endmodule
